bcd_countdown_timer: RTL and testbench

Loadable multi-digit BCD down-counter with a run/pause/done control FSM. It is the count-down counterpart of the up-counting BCD digit counters. The block is used as a preset countdown timer: software or a front-panel FSM loads a BCD preset, starts it, and one-cycle tick strobes from a prescaler decrement it. The block flags completion when the count reaches zero.

---
 rtl/bcd_countdown_timer.sv | 99 +++++++++
 tb/tb_bcd_countdown_timer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: loadable multi-digit BCD down-counter with run/pause/done control.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   reset_n    - asynchronous active-low reset
//   load       - load request, samples load_val (rejected while running)
//   load_val   - BCD preset, digit i at [4i+3:4i]
//   start      - start or resume the countdown (needs a nonzero count)
//   stop       - pause the countdown
//   tick       - one-cycle count strobe, decrements Q while running
//   Q          - current BCD count (registered)
//   running    - high in RUN
//   done       - high in DONE (level)
//   zero_pulse - one-cycle pulse when a running count reaches zero
//   load_err   - one-cycle pulse when a load carries a non-BCD digit
module bcd_countdown_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  running,
    output logic                  done,
    output logic                  zero_pulse,
    output logic                  load_err
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t              state, state_nx;
    logic [4*DIGITS-1:0] q_nx, q_dec;
    logic [DIGITS-1:0]   dig_ok, borrow;
    logic                zp_nx, le_nx, q_zero, q_last;

    // borrow[i] means digit i must decrement: all lower digits are zero
    assign borrow[0] = 1'b1;
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            if (i > 0) begin : g_b
                assign borrow[i] = borrow[i-1] & (Q[4*(i-1)+:4] == 4'd0);
            end
            assign dig_ok[i] = load_val[4*i+:4] <= 4'd9;
            assign q_dec[4*i+:4] = !borrow[i] ? Q[4*i+:4] :
                                   (Q[4*i+:4] == 4'd0) ? 4'd9 : Q[4*i+:4] - 4'd1;
        end
    endgenerate

    assign q_zero = (Q == '0);
    // decrementing a count of one is the only way q_dec reaches zero
    assign q_last = (q_dec == '0);

    always_comb begin
        state_nx = state;
        q_nx     = Q;
        zp_nx    = 1'b0;
        le_nx    = 1'b0;
        // a load while running is ignored and lets lower-priority inputs act
        if (load && state != RUN) begin
            if (&dig_ok) begin
                q_nx     = load_val;
                state_nx = IDLE;
            end else begin
                le_nx = 1'b1;
            end
        end else if (stop && state == RUN) begin
            state_nx = PAUSED;
        end else if (start && (state == IDLE || state == PAUSED)) begin
            state_nx = q_zero ? state : RUN;
        end else if (tick && state == RUN && !q_zero) begin
            q_nx = q_dec;
            if (q_last) begin
                state_nx = DONE;
                zp_nx    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            Q          <= '0;
            zero_pulse <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            Q          <= q_nx;
            zero_pulse <= zp_nx;
            load_err   <= le_nx;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: scoreboard bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] Q;
    logic        running, done, zero_pulse, load_err;

    typedef struct {
        logic [15:0] q;
        logic        r, d, z, e;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    bcd_countdown_timer #(.DIGITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .tick(tick), .Q(Q), .running(running),
        .done(done), .zero_pulse(zero_pulse), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({Q, running, done, zero_pulse, load_err} !== {e.q, e.r, e.d, e.z, e.e}) begin
                bad++;
                $display("FAIL %s: got Q=%h run=%b done=%b zp=%b le=%b, want Q=%h run=%b done=%b zp=%b le=%b",
                         e.nm, Q, running, done, zero_pulse, load_err, e.q, e.r, e.d, e.z, e.e);
            end
        end
    end

    task automatic step(input logic ld, input logic [15:0] lv, input logic st, input logic sp,
                        input logic tk, input logic [15:0] eq, input logic er, input logic ed,
                        input logic ez, input logic ee, input string nm);
        exp_t e;
        @(negedge clk);
        load = ld; load_val = lv; start = st; stop = sp; tick = tk;
        e.q = eq; e.r = er; e.d = ed; e.z = ez; e.e = ee; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk_now(input logic [15:0] eq, input logic er, input logic ed, input string nm);
        total++;
        if ({Q, running, done, zero_pulse, load_err} !== {eq, er, ed, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL %s: got Q=%h run=%b done=%b zp=%b le=%b, want Q=%h run=%b done=%b zp=0 le=0",
                     nm, Q, running, done, zero_pulse, load_err, eq, er, ed);
        end
    endtask

    logic [15:0] seq1 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                               16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};

    initial begin
        #2 chk_now(16'h0000, 0, 0, "reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // countdown from 12
        step(1, 16'h0012, 0, 0, 0, 16'h0012, 0, 0, 0, 0, "load12");
        step(0, 16'h0000, 1, 0, 0, 16'h0012, 1, 0, 0, 0, "start12");
        for (int k = 0; k < 12; k++)
            step(0, 16'h0000, 0, 0, 1, seq1[k], k != 11, k == 11, k == 11, 0, "tick12");
        step(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, "zp_once");
        step(0, 16'h0000, 1, 0, 1, 16'h0000, 0, 1, 0, 0, "done_start_tick");
        step(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 0, "done_stop");
        // borrow chains
        step(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 0, "load1000");
        step(0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0, 0, "start1000");
        step(0, 16'h0000, 0, 0, 1, 16'h0999, 1, 0, 0, 0, "borrow1000");
        step(0, 16'h0000, 0, 1, 0, 16'h0999, 0, 0, 0, 0, "stop0999");
        step(1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0, 0, "load0100");
        step(0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0, 0, 0, "start0100");
        step(0, 16'h0000, 0, 0, 1, 16'h0099, 1, 0, 0, 0, "borrow0100");
        // invalid loads and loads while running
        step(0, 16'h0000, 0, 1, 0, 16'h0099, 0, 0, 0, 0, "stop0099");
        step(1, 16'h0042, 0, 0, 0, 16'h0042, 0, 0, 0, 0, "load0042");
        step(1, 16'h00A5, 0, 0, 0, 16'h0042, 0, 0, 0, 1, "bad_load_a5");
        step(0, 16'h0000, 0, 0, 0, 16'h0042, 0, 0, 0, 0, "le_once");
        step(1, 16'h0F00, 1, 0, 0, 16'h0042, 0, 0, 0, 1, "bad_load_f00");
        step(0, 16'h0000, 1, 0, 0, 16'h0042, 1, 0, 0, 0, "start0042");
        step(1, 16'h00A5, 0, 0, 0, 16'h0042, 1, 0, 0, 0, "bad_load_run");
        step(1, 16'h0010, 0, 0, 1, 16'h0041, 1, 0, 0, 0, "load_run_tick");
        step(0, 16'h0000, 1, 1, 0, 16'h0041, 0, 0, 0, 0, "stop_over_start");
        step(1, 16'h0007, 1, 0, 0, 16'h0007, 0, 0, 0, 0, "load_over_start");
        step(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, "load0000");
        step(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, "start_zero");
        // pause and resume
        step(1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0, 0, "load0005");
        step(0, 16'h0000, 1, 0, 0, 16'h0005, 1, 0, 0, 0, "start0005");
        step(0, 16'h0000, 0, 0, 1, 16'h0004, 1, 0, 0, 0, "tick4");
        step(0, 16'h0000, 0, 0, 1, 16'h0003, 1, 0, 0, 0, "tick3");
        step(0, 16'h0000, 0, 1, 1, 16'h0003, 0, 0, 0, 0, "stop_tick");
        step(0, 16'h0000, 0, 0, 1, 16'h0003, 0, 0, 0, 0, "pause_tick");
        step(0, 16'h0000, 0, 1, 1, 16'h0003, 0, 0, 0, 0, "pause_stop_tick");
        step(0, 16'h0000, 1, 1, 0, 16'h0003, 1, 0, 0, 0, "resume");
        step(0, 16'h0000, 0, 0, 1, 16'h0002, 1, 0, 0, 0, "tick2");
        step(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0, 0, "tick1");
        step(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1, 0, "tick0");
        step(1, 16'h00B0, 0, 0, 0, 16'h0000, 0, 1, 0, 1, "bad_load_done");
        step(1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0, 0, 0, "load_from_done");
        step(0, 16'h0000, 1, 0, 0, 16'h0001, 1, 0, 0, 0, "start0001");
        step(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1, 0, "tick_last");
        // async reset mid-run
        step(1, 16'h0357, 0, 0, 0, 16'h0357, 0, 0, 0, 0, "load0357");
        step(0, 16'h0000, 1, 0, 0, 16'h0357, 1, 0, 0, 0, "start0357");
        step(0, 16'h0000, 0, 0, 0, 16'h0357, 1, 0, 0, 0, "hold0357");
        #3 reset_n = 1'b0;
        #1 chk_now(16'h0000, 0, 0, "async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 0, "post_reset_tick");
        step(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, "post_reset_start");
        step(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0, 0, "post_reset_load");
        step(0, 16'h0000, 0, 0, 0, 16'h0002, 0, 0, 0, 0, "idle_hold");
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
